// File: rtl/tetris_game_sequencer_pkg.sv
// Shared encodings for the Tetris game sequencer: candidate ops, FSM states,
// pending-flag slots and board geometry defaults.
package tetris_game_sequencer_pkg;

  localparam int ROWS_DEF        = 20;
  localparam int ROW_W_DEF       = 5;
  localparam int CHK_TIMEOUT_DEF = 15;

  // Pending-flag slots; lower index wins when several are pending.
  localparam int         PEND_N  = 6;
  localparam logic [2:0] P_DROP  = 3'd0;
  localparam logic [2:0] P_CW    = 3'd1;
  localparam logic [2:0] P_CCW   = 3'd2;
  localparam logic [2:0] P_LEFT  = 3'd3;
  localparam logic [2:0] P_RIGHT = 3'd4;
  localparam logic [2:0] P_GRAV  = 3'd5;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_CW    = 3'd1,
    OP_CCW   = 3'd2,
    OP_LEFT  = 3'd3,
    OP_RIGHT = 3'd4,
    OP_DOWN  = 3'd5,
    OP_SPAWN = 3'd6
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_NEW       = 4'd1,
    ST_SPAWN     = 4'd2,
    ST_CHECK     = 4'd3,
    ST_READY     = 4'd4,
    ST_LOCK      = 4'd5,
    ST_SCAN      = 4'd6,
    ST_SCAN_WAIT = 4'd7,
    ST_SCORE     = 4'd8,
    ST_OVER      = 4'd9
  } state_e;

  // Drop and gravity both move the piece down one row.
  function automatic op_e pend_to_op(input logic [2:0] idx);
    case (idx)
      P_CW:    return OP_CW;
      P_CCW:   return OP_CCW;
      P_LEFT:  return OP_LEFT;
      P_RIGHT: return OP_RIGHT;
      default: return OP_DOWN;
    endcase
  endfunction

endpackage

// File: rtl/tetris_pending_latch.sv
// Sticky per-op request flags fed by one-cycle key/gravity pulses, with a
// fixed-priority pick of the next op to check.
module tetris_pending_latch
  import tetris_game_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_all,
  input  logic              set_en,
  input  logic              grav_mask,
  input  logic [PEND_N-1:0] req,
  input  logic [PEND_N-1:0] clr,
  output logic [PEND_N-1:0] pend,
  output logic              sel_valid,
  output logic [2:0]        sel_idx
);

  logic [PEND_N-1:0] req_m;

  // A new pulse wins over a same-cycle clear so it is never lost.
  assign req_m = set_en ? (req & ~{grav_mask, {(PEND_N-1){1'b0}}}) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else if (clear_all) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~clr) | req_m;
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = PEND_N - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel_valid = 1'b1;
        sel_idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/tetris_game_sequencer.sv
// Central Tetris FSM: time-multiplexes one collision checker and one row
// eliminator across spawn, moves, rotations, gravity, lock, scan and score.
module tetris_game_sequencer
  import tetris_game_sequencer_pkg::*;
#(
  parameter int ROWS        = ROWS_DEF,
  parameter int ROW_W       = ROW_W_DEF,
  parameter int CHK_TIMEOUT = CHK_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             key_cw,
  input  logic             key_ccw,
  input  logic             key_left,
  input  logic             key_right,
  input  logic             key_drop,
  input  logic             gravity_tick,
  input  logic             chk_done,
  input  logic             chk_ok,
  input  logic             row_full,
  output logic             chk_req,
  output logic [2:0]       chk_op,
  output logic             commit,
  output logic             board_clear,
  output logic             spawn,
  output logic             lock,
  output logic [ROW_W-1:0] row_sel,
  output logic             row_clear,
  output logic             score_hit,
  output logic [1:0]       line_cnt,
  output logic             game_over,
  output logic             busy,
  output state_e           state_dbg
);

  localparam int TW = $clog2(CHK_TIMEOUT + 1);

  state_e            state;
  logic [TW-1:0]     timer;
  logic [2:0]        line_acc;
  logic [2:0]        cur_idx;
  logic              drop_mode;
  logic              reissue;
  logic [PEND_N-1:0] pend;
  logic [PEND_N-1:0] pend_clr;
  logic              sel_valid;
  logic [2:0]        sel_idx;
  logic              set_en;
  logic              resolve;
  logic              res_ok;
  logic              cur_is_down;

  assign set_en = (state != ST_IDLE) && (state != ST_OVER);

  tetris_pending_latch u_pend (
    .clk       (clk),
    .rst       (rst),
    .clear_all (start),
    .set_en    (set_en),
    .grav_mask (drop_mode),
    .req       ({gravity_tick, key_right, key_left, key_ccw, key_cw, key_drop}),
    .clr       (pend_clr),
    .pend      (pend),
    .sel_valid (sel_valid),
    .sel_idx   (sel_idx)
  );

  // Check handshake: chk_req pulses for one cycle with chk_op stable until
  // the check resolves; chk_done (with chk_ok) is accepted on any later cycle
  // in CHECK, and silence for CHK_TIMEOUT cycles counts as a failed check.
  // A reissue cycle between drop steps lets the previous commit land first.
  assign resolve     = (state == ST_CHECK) && !reissue &&
                       (chk_done || (timer == TW'(CHK_TIMEOUT - 1)));
  assign res_ok      = chk_done && chk_ok;
  assign cur_is_down = drop_mode || (cur_idx == P_GRAV);

  always_comb begin
    pend_clr = '0;
    if (resolve && (chk_op != OP_SPAWN)) begin
      if (!res_ok && cur_is_down) begin
        pend_clr[P_DROP] = 1'b1;
        pend_clr[P_GRAV] = 1'b1;
      end else if (!(res_ok && drop_mode)) begin
        pend_clr[cur_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      chk_req     <= 1'b0;
      chk_op      <= OP_NONE;
      commit      <= 1'b0;
      board_clear <= 1'b0;
      spawn       <= 1'b0;
      lock        <= 1'b0;
      row_sel     <= '0;
      row_clear   <= 1'b0;
      score_hit   <= 1'b0;
      line_cnt    <= '0;
      game_over   <= 1'b0;
      timer       <= '0;
      line_acc    <= '0;
      cur_idx     <= P_DROP;
      drop_mode   <= 1'b0;
      reissue     <= 1'b0;
    end else begin
      chk_req     <= 1'b0;
      commit      <= 1'b0;
      board_clear <= 1'b0;
      spawn       <= 1'b0;
      lock        <= 1'b0;
      row_clear   <= 1'b0;
      score_hit   <= 1'b0;
      if (start) begin
        state       <= ST_NEW;
        board_clear <= 1'b1;
        game_over   <= 1'b0;
        chk_op      <= OP_NONE;
        line_acc    <= '0;
        drop_mode   <= 1'b0;
        reissue     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_NEW: begin
            state <= ST_SPAWN;
            spawn <= 1'b1;
          end
          ST_SPAWN: begin
            state   <= ST_CHECK;
            chk_req <= 1'b1;
            chk_op  <= OP_SPAWN;
            cur_idx <= P_DROP;
            timer   <= '0;
          end
          ST_CHECK: begin
            if (reissue) begin
              reissue <= 1'b0;
              chk_req <= 1'b1;
              timer   <= '0;
            end else if (resolve) begin
              if (res_ok) begin
                commit <= 1'b1;
                if (drop_mode) reissue <= 1'b1;
                else           state   <= ST_READY;
              end else if (chk_op == OP_SPAWN) begin
                state     <= ST_OVER;
                game_over <= 1'b1;
              end else if (cur_is_down) begin
                drop_mode <= 1'b0;
                state     <= ST_LOCK;
                lock      <= 1'b1;
                row_sel   <= '0;
              end else begin
                state <= ST_READY;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_READY: begin
            if (sel_valid) begin
              state     <= ST_CHECK;
              chk_req   <= 1'b1;
              chk_op    <= pend_to_op(sel_idx);
              cur_idx   <= sel_idx;
              drop_mode <= (sel_idx == P_DROP);
              timer     <= '0;
            end
          end
          ST_LOCK: state <= ST_SCAN;
          ST_SCAN: begin
            if (row_full) begin
              row_clear <= 1'b1;
              if (line_acc != 3'd4) line_acc <= line_acc + 3'd1;
              state <= ST_SCAN_WAIT;
            end else if (row_sel == ROW_W'(ROWS - 1)) begin
              state <= ST_SCORE;
              if (line_acc != 3'd0) begin
                score_hit <= 1'b1;
                line_cnt  <= 2'(line_acc - 3'd1);
              end
            end else begin
              row_sel <= row_sel + 1'b1;
            end
          end
          // Rows above have shifted down; re-examine the same row_sel.
          ST_SCAN_WAIT: state <= ST_SCAN;
          ST_SCORE: begin
            line_acc <= '0;
            state    <= ST_SPAWN;
            spawn    <= 1'b1;
          end
          ST_OVER: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy      = !((state == ST_READY) || (state == ST_IDLE) || (state == ST_OVER));
  assign state_dbg = state;

endmodule

// File: doc/tetris_game_sequencer.md
Name: tetris_game_sequencer

Overview:
- Central FSM that sequences the Tetris board datapath: spawn, move/rotate checks, gravity, lock, row scan/clear, score, game over.
- Replaces the single-cycle cascade of move checks with one shared collision checker and one shared row eliminator, time-multiplexed between requests.
- Sits between the keyboard pulse generators / gravity divider and the board datapath (collision checker, combiner, row eliminator, score counter).

Parameters:
ROWS, 20, number of board rows scanned for clearing
ROW_W, 5, width of row index
CHK_TIMEOUT, 15, cycles to wait for chk_done before treating the check as failed

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  new-game pulse
key_cw  in  1  rotate-clockwise pulse
key_ccw  in  1  rotate-counter-clockwise pulse
key_left  in  1  move-left pulse
key_right  in  1  move-right pulse
key_drop  in  1  hard-drop pulse
gravity_tick  in  1  fall pulse
chk_done  in  1  collision result valid
chk_ok  in  1  candidate fits (sampled with chk_done)
row_full  in  1  row at row_sel is full (combinational from registered board)
chk_req  out  1  one-cycle check request
chk_op  out  3  candidate op: 0 NONE, 1 CW, 2 CCW, 3 LEFT, 4 RIGHT, 5 DOWN, 6 SPAWN
commit  out  1  one-cycle pulse: datapath applies chk_op
board_clear  out  1  one-cycle pulse: empty the board
spawn  out  1  one-cycle pulse: load new piece at origin
lock  out  1  one-cycle pulse: merge float into static
row_sel  out  ROW_W  row under scan
row_clear  out  1  one-cycle pulse: eliminate row_sel, shift rows above down
score_hit  out  1  one-cycle pulse: lines cleared
line_cnt  out  2  lines cleared minus 1, valid with score_hit
game_over  out  1  level, high in OVER
busy  out  1  high in every state except READY, IDLE and OVER

Behaviour:
- Reset (async): state IDLE; all pulses 0; chk_op 0; row_sel 0; line_cnt 0; game_over 0; pending flags and line counter cleared.
- States: IDLE, NEW, SPAWN, CHECK, READY, LOCK, SCAN, SCAN_WAIT, SCORE, OVER.
- start has priority in every state. Next state is NEW; pending flags and line counter cleared; any outstanding check is abandoned (a later chk_done is ignored).
- NEW: board_clear pulse, then SPAWN.
- SPAWN: spawn pulse. Next cycle, issue op 6 via CHECK.
  - Check fails -> OVER.
  - Check passes -> commit pulse, then READY.
- Pending flags, one per key plus gravity: set on an input pulse in any state except IDLE/OVER; repeated pulses coalesce.
- READY: pick the highest-priority pending op, in order: drop, CW, CCW, LEFT, RIGHT, gravity (as DOWN). None pending -> stay.
- CHECK:
  - chk_req high for the first cycle only; chk_op held until resolution.
  - Resolves on chk_done, or on timeout after CHK_TIMEOUT cycles (treated as chk_ok=0).
  - ok: commit pulse, clear that op's flag. In drop mode, reissue DOWN without returning to READY.
  - fail on DOWN (gravity or drop): clear drop and gravity flags, go to LOCK.
  - fail on other ops: clear that flag, go to READY.
- Gravity pulses arriving during drop mode are discarded.
- LOCK: lock pulse; row_sel <= 0; go to SCAN.
- SCAN:
  - row_full=1: row_clear pulse, line counter +1 (saturating at 4), go to SCAN_WAIT. After one cycle, return to SCAN with the same row_sel so the shifted-down row is re-examined.
  - row_full=0: if row_sel = ROWS-1, go to SCORE; else row_sel +1.
- SCORE: if count > 0, score_hit pulse with line_cnt = count-1. Clear count; go to SPAWN.
- OVER: game_over=1. Ignores everything except start.
- At most one of commit/spawn/lock/row_clear/board_clear is asserted in any cycle.

Decomposition:
- Shared package: op encodings (OP_NONE..OP_SPAWN), state encodings, ROWS and ROW_W defaults.
- One sub-module: tetris_pending_latch (per-op sticky flags with set/clear/priority select), instantiated once.

Test Plan:
- Reset mid-CHECK, then release: all outputs 0, state IDLE; start -> board_clear at t+1, spawn at t+2, chk_req with op 6 at t+3.
- Spawn check with chk_ok=0 -> game_over=1 next cycle; key pulses ignored; start -> game_over=0, board_clear pulse.
- key_left and key_cw in the same cycle, both checks ok -> chk_op 1 committed first, then 3; two commit pulses; READY reached.
- key_drop with 3 ok DOWN checks then a fail -> 3 commits, lock pulse, SCAN from row 0; an interleaved gravity_tick produces no extra check.
- Lock with rows 0 and 1 full (row_full=1 twice at row_sel 0, then 0) -> two row_clear pulses at row_sel=0, scan continues to row 19, then score_hit with line_cnt=1, then spawn.
- chk_done never asserted -> resolution after exactly CHK_TIMEOUT=15 cycles as a fail; a LEFT op returns to READY with no commit.
